// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit that owns HI/LO.
// Results are computed at accept time and committed when the busy countdown expires.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MULDIVMode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HILOSel,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MULDIVOut
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi, lo, temp_hi, temp_lo;
  logic          pend_vld;

  logic is_mul, is_div, accept, done;
  assign is_mul = (MULDIVMode == 4'd1) || (MULDIVMode == 4'd2);
  assign is_div = (MULDIVMode == 4'd3) || (MULDIVMode == 4'd4);
  assign accept = (state == IDLE) && (is_mul || is_div);
  assign done   = (state == BUSY) && (cnt == CW'(1));

  // Arithmetic datapath
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_sdiv, b_udiv, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes; the 0x80000000 / -1 case falls out naturally.
  assign b_zero = (B == 32'd0);
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign b_sdiv = b_zero ? 32'd1 : b_mag;
  assign b_udiv = b_zero ? 32'd1 : B;
  assign q_mag  = a_mag / b_sdiv;
  assign r_mag  = a_mag % b_sdiv;
  assign q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = A / b_udiv;
  assign r_u    = A % b_udiv;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nxt = BUSY;
        cnt_nxt   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    Start = accept;
    Busy  = (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      temp_hi  <= '0;
      temp_lo  <= '0;
      pend_vld <= 1'b0;
    end else if (accept) begin
      pend_vld <= !(is_div && b_zero);
      case (MULDIVMode)
        4'd1:    {temp_hi, temp_lo} <= prod_s;
        4'd2:    {temp_hi, temp_lo} <= prod_u;
        4'd3:    {temp_hi, temp_lo} <= {r_s, q_s};
        default: {temp_hi, temp_lo} <= {r_u, q_u};
      endcase
    end else if (done) begin
      if (pend_vld) begin
        hi <= temp_hi;
        lo <= temp_lo;
      end
      pend_vld <= 1'b0;
    end else if (state == IDLE) begin
      if (MULDIVMode == 4'd5) hi <= A;
      if (MULDIVMode == 4'd6) lo <= A;
    end
  end

  assign MULDIVOut = HILOSel ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference of HI/LO.
module tb_muldiv_unit;

  logic        clk, reset, HILOSel, Start, Busy;
  logic [3:0]  MULDIVMode;
  logic [31:0] A, B, MULDIVOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MULDIVMode(MULDIVMode), .A(A), .B(B),
    .HILOSel(HILOSel), .Start(Start), .Busy(Busy), .MULDIVOut(MULDIVOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of one op on HI/LO.
  task automatic ref_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    longint signed   ps;
    longint unsigned pu;
    int sa, sb;
    case (m)
      4'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = ps; end
      4'd2: begin pu = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = pu; end
      4'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          sa = a; sb = b;
          m_lo = sa / sb; m_hi = sa % sb;
        end
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic check_hilo(input string tag);
    HILOSel = 1'b1; #1 chk({tag, "_hi"}, MULDIVOut, m_hi);
    HILOSel = 1'b0; #1 chk({tag, "_lo"}, MULDIVOut, m_lo);
  endtask

  task automatic run_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic exp_start;
    int exp_len;
    exp_start = (m >= 4'd1 && m <= 4'd4);
    exp_len   = (m == 4'd1 || m == 4'd2) ? 5 : (m == 4'd3 || m == 4'd4) ? 10 : 0;
    @(negedge clk);
    MULDIVMode = m; A = a; B = b;
    #1 chk("start", 32'(Start), 32'(exp_start));
    @(negedge clk);
    MULDIVMode = 4'd0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 32'(exp_len));
    ref_op(m, a, b);
    check_hilo("result");
  endtask

  initial begin
    int n;
    logic [3:0]  m;
    logic [31:0] a, b;
    reset = 1'b1; MULDIVMode = 4'd0; A = '0; B = '0; HILOSel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_start", 32'(Start), 32'd0);
    check_hilo("rst");

    // Directed cases
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd4, 32'd7, 32'd2);
    run_op(4'd5, 32'h1234_5678, 32'd0);
    run_op(4'd6, 32'h9ABC_DEF0, 32'd0);
    run_op(4'd5, 32'h11, 32'd0);
    run_op(4'd6, 32'h22, 32'd0);
    run_op(4'd3, 32'd100, 32'd0);
    run_op(4'd4, 32'd100, 32'd0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd7, 32'hDEAD_BEEF, 32'd1);

    // Ops presented mid-MULT are ignored
    @(negedge clk);
    MULDIVMode = 4'd1; A = 32'h0001_0003; B = 32'hFFFF_0007;
    @(negedge clk);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      case (n)
        2: begin MULDIVMode = 4'd6; A = 32'h55; #1 chk("ign_mtlo_start", 32'(Start), 32'd0); end
        3: begin MULDIVMode = 4'd4; A = 32'd9; B = 32'd4; #1 chk("ign_divu_start", 32'(Start), 32'd0); end
        default: MULDIVMode = 4'd0;
      endcase
      @(negedge clk);
    end
    MULDIVMode = 4'd0;
    chk("ign_busy_len", 32'(n), 32'd5);
    ref_op(4'd1, 32'h0001_0003, 32'hFFFF_0007);
    check_hilo("ign");

    // Randomized ops with boundary operands mixed in
    for (int i = 0; i < 60; i++) begin
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) m = 4'($urandom_range(1, 6));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(m, a, b);
    end

    // Reset mid-DIV when counter has reached 4
    run_op(4'd5, 32'hAAAA_0001, 32'd0);
    run_op(4'd6, 32'h5555_0002, 32'd0);
    @(negedge clk);
    MULDIVMode = 4'd3; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    MULDIVMode = 4'd0;
    n = 0;
    while (Busy === 1'b1 && n < 7) begin
      n++;
      if (n < 7) @(negedge clk);
    end
    chk("pre_rst_busy_cycles", 32'(n), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1 chk("midrst_busy", 32'(Busy), 32'd0);
    check_hilo("midrst");
    repeat (15) @(negedge clk);
    chk("midrst_late_busy", 32'(Busy), 32'd0);
    check_hilo("midrst_late");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
